// File: rtl/fc_layer_p.sv
// fc_layer_p: fully connected layer y = sat(act(W * x)) with P parallel MAC lanes.
// A vector x of M samples is streamed in, N outputs are produced in row order,
// P rows at a time. Weights live in a local memory written while idle.
module fc_layer_p #(
    parameter int unsigned M    = 4,
    parameter int unsigned N    = 8,
    parameter int unsigned T    = 16,
    parameter int unsigned P    = 2,
    parameter int unsigned RELU = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      w_wr_en,
    input  logic [$clog2(M*N)-1:0]    w_addr,
    input  logic signed [T-1:0]       w_data,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  logic signed [T-1:0]       input_data,
    output logic                      output_valid,
    input  logic                      output_ready,
    output logic signed [T-1:0]       output_data
);

    localparam int unsigned AW   = $clog2(M * N);
    localparam int unsigned XW   = $clog2(M);
    localparam int unsigned CW   = $clog2(M + 1);
    localparam int unsigned G    = N / P;
    localparam int unsigned GW   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned KW   = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PW   = 2 * T;
    localparam int unsigned ACCW = 2 * T + $clog2(M);

    localparam logic signed [T-1:0]    TMAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0]    TMIN = {1'b1, {(T-1){1'b0}}};
    localparam logic signed [ACCW-1:0] SMAX = ACCW'(TMAX);
    localparam logic signed [ACCW-1:0] SMIN = ACCW'(TMIN);

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [XW-1:0]          cnt_q;
    logic [CW-1:0]          mc_q;
    logic [GW-1:0]          g_q;
    logic [KW-1:0]          k_q;

    logic signed [T-1:0]    w_mem [M*N];
    logic signed [T-1:0]    x_buf [M];
    logic signed [ACCW-1:0] acc_q [P];
    logic signed [T-1:0]    res_q [P];

    logic [XW-1:0]          col_c;
    logic signed [ACCW-1:0] term_c [P];
    logic signed [T-1:0]    act_c [P];

    // Optional ReLU followed by clamp to the signed T-bit range
    function automatic logic signed [T-1:0] sat_act(input logic signed [ACCW-1:0] s);
        logic signed [ACCW-1:0] a;
        a = s;
        if ((RELU != 0) && s[ACCW-1]) begin
            a = '0;
        end
        if (a > SMAX) begin
            sat_act = TMAX;
        end else if (a < SMIN) begin
            sat_act = TMIN;
        end else begin
            sat_act = T'(a);
        end
    endfunction

    // Column being accumulated; parked at 0 on the final result-capture cycle
    assign col_c = (mc_q < CW'(M)) ? XW'(mc_q) : '0;

    // Per-lane full-width product and activated/saturated accumulator value
    always_comb begin
        logic [AW-1:0]        w_idx;
        logic signed [PW-1:0] prod;
        w_idx = '0;
        prod  = '0;
        for (int l = 0; l < int'(P); l++) begin
            w_idx     = AW'((int'(g_q) * int'(P) + l) * int'(M) + int'(col_c));
            prod      = PW'(w_mem[w_idx]) * PW'(x_buf[col_c]);
            term_c[l] = ACCW'(prod);
            act_c[l]  = sat_act(acc_q[l]);
        end
    end

    // Weight store: writes accepted only while idle before the first x sample
    always_ff @(posedge clk) begin
        if (w_wr_en && (state_q == LOAD_X) && (cnt_q == '0)) begin
            w_mem[w_addr] <= w_data;
        end
    end

    // x buffer: captures each accepted input sample at its index
    always_ff @(posedge clk) begin
        if ((state_q == LOAD_X) && input_valid) begin
            x_buf[cnt_q] <= input_data;
        end
    end

    // Control FSM, MAC accumulation and registered stream outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LOAD_X;
            cnt_q        <= '0;
            mc_q         <= '0;
            g_q          <= '0;
            k_q          <= '0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
            output_data  <= '0;
            for (int l = 0; l < int'(P); l++) begin
                acc_q[l] <= '0;
                res_q[l] <= '0;
            end
        end else begin
            case (state_q)
                LOAD_X: begin
                    if (input_valid) begin
                        if (cnt_q == XW'(M - 1)) begin
                            cnt_q       <= '0;
                            g_q         <= '0;
                            mc_q        <= '0;
                            input_ready <= 1'b0;
                            state_q     <= COMPUTE;
                            for (int l = 0; l < int'(P); l++) begin
                                acc_q[l] <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + XW'(1);
                        end
                    end
                end

                COMPUTE: begin
                    if (mc_q != CW'(M)) begin
                        mc_q <= mc_q + CW'(1);
                        for (int l = 0; l < int'(P); l++) begin
                            acc_q[l] <= acc_q[l] + term_c[l];
                        end
                    end else begin
                        for (int l = 0; l < int'(P); l++) begin
                            res_q[l] <= act_c[l];
                        end
                        output_data  <= act_c[0];
                        output_valid <= 1'b1;
                        k_q          <= '0;
                        state_q      <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (output_ready) begin
                        if (k_q == KW'(P - 1)) begin
                            output_valid <= 1'b0;
                            mc_q         <= '0;
                            for (int l = 0; l < int'(P); l++) begin
                                acc_q[l] <= '0;
                            end
                            if (g_q == GW'(G - 1)) begin
                                g_q         <= '0;
                                cnt_q       <= '0;
                                input_ready <= 1'b1;
                                state_q     <= LOAD_X;
                            end else begin
                                g_q     <= g_q + GW'(1);
                                state_q <= COMPUTE;
                            end
                        end else begin
                            k_q         <= k_q + KW'(1);
                            output_data <= res_q[k_q + KW'(1)];
                        end
                    end
                end

                default: begin
                    state_q <= LOAD_X;
                end
            endcase
        end
    end

endmodule
